mpu_spi_slave_model: RTL and testbench
======================================

Name: mpu_spi_slave_model

Overview:
- SPI responder that emulates the MPU9250 register interface on the gyro SPI bus: SPI mode 3, 16-bit frames, MSB first.
- Lets the gyro SPI controller and its SPI master run closed-loop in simulation, or against a loopback on the FPGA, without a physical sensor.
- A host-side sample port loads gyro values into the data registers. Master writes are reported on a strobe port.

Parameters:
- WHOAMI_VAL, 8'h71, value returned at address 0x75.
- PWR_MGMT_1_RST, 8'h01, reset value of register 0x6B.

Ports:
- clk  in  1  system clock; must be at least 4x the SCK frequency.
- reset_n  in  1  reset, asynchronous and active-low.
- spi_ss_n  in  1  slave select from the master's SPI_SS_g; active low.
- spi_ck  in  1  SCK from the master's SPI_CK_g; idles high.
- spi_mosi  in  1  from the master's SPI_DO_g.
- spi_miso  out  1  to the master's SPI_DI_g.
- spi_miso_oe  out  1  high while this block drives MISO.
- sample_valid  in  1  one-cycle load strobe for the sample inputs.
- sample_gyro_x  in  16  gyro X, {H,L}.
- sample_gyro_y  in  16  gyro Y, {H,L}.
- sample_gyro_z  in  16  gyro Z, {H,L}.
- wr_strobe  out  1  one-cycle pulse per completed write frame.
- wr_addr  out  7  address of the last write frame.
- wr_data  out  8  data of the last write frame.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- frame_cnt  out  16  completed frames (reads and writes); wraps 0xFFFF->0.

Behaviour:
- Input sync: spi_ss_n, spi_ck and spi_mosi each pass through a 2-flop synchronizer. Edges are detected on the synchronized SCK; all logic runs in the clk domain.
- Frame format: bit15 is R/W (1 = read), bits14:8 are address[6:0], bits7:0 are data. Bits are sampled on SCK rising edges.
- Register map:
  - 0x43..0x48: gyro XH, XL, YH, YL, ZH, ZL. Read-only. Reset 0x00. Loaded from the sample inputs on sample_valid.
  - 0x37: read/write, reset 0x00.
  - 0x6B: read/write, reset PWR_MGMT_1_RST.
  - 0x75: read-only, returns WHOAMI_VAL.
  - All other addresses read 0x00; writes to them are dropped from storage.
- Write reporting: every completed write frame pulses wr_strobe with its wr_addr/wr_data, including writes to read-only or unmapped addresses.
- States:
  - IDLE: waits for sync SS falling edge. On entry, bit_cnt <= 0 → ADDR.
  - ADDR: shifts in 8 bits. On the 8th rising edge, latch rw/addr and load tx_byte <= reg[addr] in the same clk cycle → DATA.
  - DATA, read: spi_miso_oe = 1. On each SCK falling edge, drive tx_byte MSB, then shift left. The first falling edge after the 8th rising edge presents bit7.
  - DATA, write: shift in mosi.
  - On the 16th rising edge: a write commits to the register (writable addresses only), wr_strobe pulses the next cycle, frame_cnt += 1 → DONE.
  - DONE: ignores further SCK edges. On SS rising edge → IDLE.
- Outputs while not in read DATA: spi_miso = 0, spi_miso_oe = 0.
- Abort: SS rising edge in ADDR or DATA before 16 bits gives no commit, no frame_cnt increment, a one-cycle frame_err pulse, and a return to IDLE.
- sample_valid coincident with a read: the register array updates immediately. A tx_byte already latched is unaffected, so a byte is never torn.
- sample_valid in the same cycle as a committed write: both happen, since they target disjoint registers.
- Reset (any time, including mid-frame):
  - All registers go to their reset values.
  - Outputs: spi_miso=0, spi_miso_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, frame_err=0, frame_cnt=0. State → IDLE.
  - If SS is already low at reset release, the partial frame is ignored. The block re-arms only after SS is seen high.

Test Plan:
- Read 0x75: the master sends 16'hF5xx → MISO returns 8'h71; frame_cnt=1; no wr_strobe.
- Write 0x6B: 16'h6B00, then read 16'hEBxx → wr_strobe with addr=0x6B, data=0x00; the read returns 0x00. Before the write, the read returns 0x01.
- Gyro data: sample_valid with x=16'h1234, y=16'hABCD, z=16'h8001, then six reads 0xC3..0xC8 → 12,34,AB,CD,80,01 in order.
- Abort: SS high after 10 SCK edges of write 16'h3702 → frame_err pulses; a later read of 0x37 returns 0x00; frame_cnt unchanged.
- Tear check: start a read of 0x43 with reg=0x12; assert sample_valid x=16'h5600 after the 8th rising edge → returns 0x12; the next read returns 0x56.
- Reset mid-frame: assert reset_n low during the DATA phase and release with SS still low → no response until SS goes high; the next frame completes normally with frame_cnt=1.

Source files
------------

// File: rtl/mpu_spi_slave_model.sv
// ----------------------------------------------------------------------------
// mpu_spi_slave_model
//
// Emulates the MPU9250 register interface on the gyro SPI bus so the gyro SPI
// controller and its SPI master can run closed-loop without a real sensor.
// SPI mode 3 (SCK idles high, sample on rising edge, drive on falling edge),
// 16-bit frames, MSB first: {rw, addr[6:0], data[7:0]}, rw = 1 means read.
// All SPI inputs are synchronized into the clk domain, so clk must run at
// least 4x faster than SCK.
//
// Ports:
//   clk_i            system clock
//   reset_n_i        asynchronous active-low reset
//   spi_ss_n_i       slave select, active low
//   spi_ck_i         SCK, idles high
//   spi_mosi_i       master-out data
//   spi_miso_o       master-in data (0 when not driving)
//   spi_miso_oe_o    high while a read data byte is being driven
//   sample_valid_i   one-cycle load strobe for the gyro sample inputs
//   sample_gyro_*_i  gyro X/Y/Z samples, {H,L}
//   wr_strobe_o      one-cycle pulse per completed write frame
//   wr_addr_o        address of the last write frame
//   wr_data_o        data of the last write frame
//   frame_err_o      one-cycle pulse when a frame is aborted by SS rising
//   frame_cnt_o      count of completed frames, wraps
// ----------------------------------------------------------------------------
module mpu_spi_slave_model #(
    parameter logic [7:0] WHOAMI_VAL     = 8'h71,
    parameter logic [7:0] PWR_MGMT_1_RST = 8'h01
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        spi_ss_n_i,
    input  logic        spi_ck_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe_o,
    input  logic        sample_valid_i,
    input  logic [15:0] sample_gyro_x_i,
    input  logic [15:0] sample_gyro_y_i,
    input  logic [15:0] sample_gyro_z_i,
    output logic        wr_strobe_o,
    output logic [6:0]  wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        frame_err_o,
    output logic [15:0] frame_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_e;

    state_e state_q, state_d;

    logic [1:0]  ss_sync_q, ck_sync_q, mosi_sync_q;
    logic        ss_prev_q, ck_prev_q;
    logic        ss_fall, ss_rise, ck_rise, ck_fall;

    logic [3:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  new_byte;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic [7:0]  tx_q;
    logic        miso_q;
    logic [7:0]  rd_byte;

    logic        wr_strobe_q, frame_err_q;
    logic [6:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [15:0] frame_cnt_q;

    // {XH, XL, YH, YL, ZH, ZL}
    logic [47:0] gyro_q;
    logic [7:0]  reg37_q, reg6b_q;

    logic arm, shift_en, latch_hdr, drive_en, commit, abort;

    // SS and its edge history reset to 0: if SS is already low when reset
    // releases, no falling edge is ever seen until SS first goes high again,
    // so a partial frame is ignored.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ss_sync_q   <= 2'b00;
            ck_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            ss_prev_q   <= 1'b0;
            ck_prev_q   <= 1'b1;
        end else begin
            ss_sync_q   <= {ss_sync_q[0], spi_ss_n_i};
            ck_sync_q   <= {ck_sync_q[0], spi_ck_i};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
            ss_prev_q   <= ss_sync_q[1];
            ck_prev_q   <= ck_sync_q[1];
        end
    end

    assign ss_fall  = ss_prev_q & ~ss_sync_q[1];
    assign ss_rise  = ~ss_prev_q & ss_sync_q[1];
    assign ck_rise  = ~ck_prev_q & ck_sync_q[1];
    assign ck_fall  = ck_prev_q & ~ck_sync_q[1];
    assign new_byte = {shift_q, mosi_sync_q[1]};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        arm       = 1'b0;
        shift_en  = 1'b0;
        latch_hdr = 1'b0;
        drive_en  = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    arm     = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ss_rise) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (ck_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == 4'd7) begin
                        latch_hdr = 1'b1;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (ss_rise) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    drive_en = ck_fall & rw_q;
                    if (ck_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt_q == 4'd15) begin
                            commit  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (ss_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register read mux, addressed by the header byte as it completes so the
    // transmit byte is captured in the same cycle as the address.
    always_comb begin
        rd_byte = 8'h00;
        case (new_byte[6:0])
            7'h43:   rd_byte = gyro_q[47:40];
            7'h44:   rd_byte = gyro_q[39:32];
            7'h45:   rd_byte = gyro_q[31:24];
            7'h46:   rd_byte = gyro_q[23:16];
            7'h47:   rd_byte = gyro_q[15:8];
            7'h48:   rd_byte = gyro_q[7:0];
            7'h37:   rd_byte = reg37_q;
            7'h6B:   rd_byte = reg6b_q;
            7'h75:   rd_byte = WHOAMI_VAL;
            default: rd_byte = 8'h00;
        endcase
    end

    // Frame datapath. tx_q is a private copy of the addressed register, so a
    // sample load during the data phase never tears the byte being sent.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'd0;
            rw_q        <= 1'b0;
            addr_q      <= 7'd0;
            tx_q        <= 8'd0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 8'd0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 16'd0;
            gyro_q      <= 48'd0;
            reg37_q     <= 8'h00;
            reg6b_q     <= PWR_MGMT_1_RST;
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= abort;
            if (arm) begin
                bit_cnt_q <= 4'd0;
            end
            if (shift_en) begin
                shift_q   <= new_byte[6:0];
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (latch_hdr) begin
                rw_q   <= new_byte[7];
                addr_q <= new_byte[6:0];
                tx_q   <= rd_byte;
                miso_q <= 1'b0;
            end
            if (drive_en) begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
            end
            if (commit) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (!rw_q) begin
                    wr_strobe_q <= 1'b1;
                    wr_addr_q   <= addr_q;
                    wr_data_q   <= new_byte;
                    if (addr_q == 7'h37) reg37_q <= new_byte;
                    if (addr_q == 7'h6B) reg6b_q <= new_byte;
                end
            end
            if (sample_valid_i) begin
                gyro_q <= {sample_gyro_x_i, sample_gyro_y_i, sample_gyro_z_i};
            end
        end
    end

    assign spi_miso_oe_o = (state_q == ST_DATA) && rw_q;
    assign spi_miso_o    = spi_miso_oe_o & miso_q;
    assign wr_strobe_o   = wr_strobe_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign frame_err_o   = frame_err_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_mpu_spi_slave_model.sv
// ----------------------------------------------------------------------------
// tb_mpu_spi_slave_model
//
// Acts as a mode-3 SPI master against mpu_spi_slave_model. A register-table
// model of the MPU9250 map (128 bytes, only 0x37/0x6B writable, gyro bytes
// loaded by samples) predicts read data, write reports and frame counts.
// ----------------------------------------------------------------------------
module tb_mpu_spi_slave_model;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_ss_n, spi_ck, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic        sample_valid;
    logic [15:0] gyroX, gyroY, gyroZ;
    logic        wr_strobe, frame_err;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] frame_cnt;

    int          testsRun    = 0;
    int          testsFailed = 0;

    // Observed pulse counts and last reported write
    int          wrSeen  = 0;
    int          errSeen = 0;
    logic [6:0]  lastWrAddr = '0;
    logic [7:0]  lastWrData = '0;

    // Reference model state
    logic [7:0]  modelMem [128];
    int          modelFrames;
    int          expWr  = 0;
    int          expErr = 0;
    logic [15:0] curX, curY, curZ;

    always #5 clk = ~clk;

    mpu_spi_slave_model dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .spi_ss_n_i      (spi_ss_n),
        .spi_ck_i        (spi_ck),
        .spi_mosi_i      (spi_mosi),
        .spi_miso_o      (spi_miso),
        .spi_miso_oe_o   (spi_miso_oe),
        .sample_valid_i  (sample_valid),
        .sample_gyro_x_i (gyroX),
        .sample_gyro_y_i (gyroY),
        .sample_gyro_z_i (gyroZ),
        .wr_strobe_o     (wr_strobe),
        .wr_addr_o       (wr_addr),
        .wr_data_o       (wr_data),
        .frame_err_o     (frame_err),
        .frame_cnt_o     (frame_cnt)
    );

    // Pulse monitor: sampled on the falling clock edge, away from updates
    always @(negedge clk) begin
        if (wr_strobe) begin
            wrSeen++;
            lastWrAddr = wr_addr;
            lastWrData = wr_data;
        end
        if (frame_err) errSeen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int a = 0; a < 128; a++) modelMem[a] = 8'h00;
        modelMem[7'h6B] = 8'h01;
        modelMem[7'h75] = 8'h71;
        modelFrames = 0;
        curX = '0; curY = '0; curZ = '0;
    endtask

    task automatic pulseSample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        gyroX = x; gyroY = y; gyroZ = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        curX = x; curY = y; curZ = z;
        modelMem[7'h43] = x[15:8]; modelMem[7'h44] = x[7:0];
        modelMem[7'h45] = y[15:8]; modelMem[7'h46] = y[7:0];
        modelMem[7'h47] = z[15:8]; modelMem[7'h48] = z[7:0];
    endtask

    // One master frame. stopAfter = rising edges before SS is raised (16 for
    // a full frame); tearAt / resetAt inject a sample load or a reset pulse
    // before bit index i is driven (-1 disables).
    task automatic applyStimulus(input logic [15:0] word, input int stopAfter, input int tearAt,
                                 input logic [15:0] tearX, input int resetAt,
                                 output logic [7:0] rx, output logic oeSeen);
        rx = 8'h00;
        oeSeen = 1'b0;
        spi_ss_n = 1'b0;
        #40;
        for (int i = 0; i < 16; i++) begin
            if (i == stopAfter) break;
            if (i == tearAt) pulseSample(tearX, curY, curZ);
            if (i == resetAt) begin
                reset_n = 1'b0;
                #20;
                reset_n = 1'b1;
            end
            spi_ck   = 1'b0;
            spi_mosi = word[15-i];
            #40;
            if (i >= 8) rx[15-i] = spi_miso;
            if (i == 8) oeSeen = spi_miso_oe;
            spi_ck = 1'b1;
            #40;
        end
        #40;
        spi_ss_n = 1'b1;
        #80;
    endtask

    // Runs a frame and checks everything the model predicts for it
    task automatic doFrame(input logic [15:0] word, input int stopAfter, input int tearAt, input logic [15:0] tearX);
        logic [7:0] rx;
        logic       oeSeen;
        logic [6:0] addr;
        logic       isRead;
        logic [7:0] expRd;
        addr   = word[14:8];
        isRead = word[15];
        expRd  = modelMem[addr];
        applyStimulus(word, stopAfter, tearAt, tearX, -1, rx, oeSeen);
        if (stopAfter > 8) checkOutput("miso_oe", {31'd0, oeSeen}, {31'd0, isRead});
        if (stopAfter >= 16) begin
            modelFrames++;
            if (isRead) begin
                checkOutput($sformatf("rd_%02h", addr), {24'd0, rx}, {24'd0, expRd});
            end else begin
                expWr++;
                checkOutput("wr_addr", {25'd0, lastWrAddr}, {25'd0, addr});
                checkOutput("wr_data", {24'd0, lastWrData}, {24'd0, word[7:0]});
                if (addr == 7'h37 || addr == 7'h6B) modelMem[addr] = word[7:0];
            end
        end else begin
            expErr++;
        end
        checkOutput("wr_strobe_cnt", wrSeen, expWr);
        checkOutput("frame_err_cnt", errSeen, expErr);
        checkOutput("frame_cnt", {16'd0, frame_cnt}, modelFrames & 32'hFFFF);
        checkOutput("idle_oe", {30'd0, spi_miso_oe, spi_miso}, 32'd0);
    endtask

    initial begin
        logic [6:0]  addrTab [10];
        logic [7:0]  rx;
        logic        oeSeen;
        logic [15:0] word;
        int          stop;

        addrTab = '{7'h37, 7'h6B, 7'h75, 7'h43, 7'h44, 7'h45, 7'h46, 7'h47, 7'h48, 7'h10};

        reset_n = 1'b0; spi_ss_n = 1'b1; spi_ck = 1'b1; spi_mosi = 1'b0;
        sample_valid = 1'b0; gyroX = '0; gyroY = '0; gyroZ = '0;
        modelReset();
        #32;
        checkOutput("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        checkOutput("rst_outs", {spi_miso, spi_miso_oe, wr_strobe, frame_err}, 32'd0);
        checkOutput("rst_wr", {wr_addr, wr_data}, 32'd0);
        reset_n = 1'b1;
        #53;

        // Directed: WHOAMI, PWR_MGMT_1 write/readback, gyro bytes
        doFrame(16'hF5A5, 16, -1, 16'h0);
        doFrame(16'hEB00, 16, -1, 16'h0);
        doFrame(16'h6B00, 16, -1, 16'h0);
        doFrame(16'hEBFF, 16, -1, 16'h0);
        pulseSample(16'h1234, 16'hABCD, 16'h8001);
        for (int a = 8'hC3; a <= 8'hC8; a++) doFrame({a[7:0], 8'h00}, 16, -1, 16'h0);

        // Abort after 10 edges, then 0x37 must still read zero
        doFrame(16'h3702, 10, -1, 16'h0);
        doFrame(16'hB700, 16, -1, 16'h0);

        // Tear: sample load mid-read of 0x43 must not change the byte in flight
        doFrame(16'hC300, 16, 8, 16'h5600);
        doFrame(16'hC300, 16, -1, 16'h0);

        // Randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0)
                pulseSample(16'($urandom), 16'($urandom), 16'($urandom));
            word = {1'($urandom), addrTab[$urandom_range(0, 9)], 8'($urandom)};
            if ($urandom_range(0, 7) == 0) word[14:8] = 7'($urandom);
            stop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 16;
            doFrame(word, stop, -1, 16'h0);
        end

        // Reset during the data phase with SS held low: the rest is ignored
        doFrame(16'h6B5A, 16, -1, 16'h0);
        applyStimulus(16'h3755, 16, -1, 16'h0, 12, rx, oeSeen);
        modelReset();
        checkOutput("rstmid_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        checkOutput("rstmid_wr_cnt", wrSeen, expWr);
        checkOutput("rstmid_err_cnt", errSeen, expErr);
        checkOutput("rstmid_wr_addr", {25'd0, wr_addr}, 32'd0);
        doFrame(16'hF500, 16, -1, 16'h0);
        doFrame(16'hB700, 16, -1, 16'h0);
        doFrame(16'hEB00, 16, -1, 16'h0);
        doFrame(16'hC400, 16, -1, 16'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
